exu_muldiv: RTL and testbench

EXU_MULDIV -- requirements
Module: exu_muldiv

---
 rtl/exu_pkg.sv | 27 ++
 rtl/exu_muldiv.sv | 186 ++++++++++++++++++
 tb/tb_exu_muldiv.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/exu_pkg.sv
// Shared execution-unit definitions: RV M-extension op-codes and the
// multiply/divide sequencer states, used by the decoder and by exu_muldiv.
package exu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  // The upper funct3 bit separates the divide family from the multiply family.
  function automatic logic opIsDiv(input op_e opCode);
    return opCode[2];
  endfunction

endpackage

// File: rtl/exu_muldiv.sv
// Iterative RV M-extension multiply/divide unit. Signed operations iterate on
// magnitudes (radix-2 shift-add or restoring division, one bit per cycle) and
// fix the sign when the result is latched. Divide-by-zero and signed overflow
// are resolved at acceptance without iterating.
module exu_muldiv
  import exu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_e            r_state;
  state_e            w_nextState;
  op_e               r_op;
  logic              r_negRes;
  logic [XLEN-1:0]   r_opB;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [CNT_W-1:0]  r_count;
  logic [XLEN-1:0]   r_result;

  op_e               w_opIn;
  logic              w_accept;
  logic              w_signA;
  logic              w_signB;
  logic [XLEN-1:0]   w_magA;
  logic [XLEN-1:0]   w_magB;
  logic              w_divZero;
  logic              w_divOvf;
  logic              w_special;
  logic [XLEN-1:0]   w_specialResult;
  logic              w_lastStep;

  logic [XLEN:0]     w_mulSum;
  logic [XLEN:0]     w_remShift;
  logic              w_divFits;
  logic [XLEN-1:0]   w_stepHi;
  logic [XLEN-1:0]   w_stepLo;
  logic [2*XLEN-1:0] w_prodRaw;
  logic [2*XLEN-1:0] w_prodFix;
  logic [XLEN-1:0]   w_quoFix;
  logic [XLEN-1:0]   w_remFix;
  logic [XLEN-1:0]   w_finalResult;

  assign w_opIn     = op_e'(op[2:0]);
  assign w_accept   = (r_state == ST_IDLE) && in_valid && !flush;
  assign w_lastStep = (r_count == CNT_W'(XLEN - 1));

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign result    = r_result;

  // Decode operand signedness, magnitudes and the no-iteration corner cases of an incoming request.
  always_comb begin
    w_signA = 1'b0;
    w_signB = 1'b0;
    unique case (w_opIn)
      OP_MULH, OP_DIV, OP_REM: begin
        w_signA = rs1_data[XLEN-1];
        w_signB = rs2_data[XLEN-1];
      end
      OP_MULHSU: w_signA = rs1_data[XLEN-1];
      default: ;
    endcase
    w_magA    = w_signA ? -rs1_data : rs1_data;
    w_magB    = w_signB ? -rs2_data : rs2_data;
    w_divZero = opIsDiv(w_opIn) && (rs2_data == '0);
    w_divOvf  = ((w_opIn == OP_DIV) || (w_opIn == OP_REM)) &&
                (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    w_special = w_divZero || w_divOvf;
    if (w_divZero) begin
      w_specialResult = ((w_opIn == OP_DIV) || (w_opIn == OP_DIVU)) ? '1 : rs1_data;
    end else begin
      w_specialResult = (w_opIn == OP_DIV) ? rs1_data : '0;
    end
  end

  // One radix-2 step: shift-add for multiply, restore-compare-subtract for divide.
  always_comb begin
    w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opB} : {(XLEN+1){1'b0}});
    w_remShift = {r_hi, r_lo[XLEN-1]};
    w_divFits  = (w_remShift >= {1'b0, r_opB});
    if (opIsDiv(r_op)) begin
      w_stepHi = w_divFits ? (w_remShift[XLEN-1:0] - r_opB) : w_remShift[XLEN-1:0];
      w_stepLo = {r_lo[XLEN-2:0], w_divFits};
    end else begin
      w_stepHi = w_mulSum[XLEN:1];
      w_stepLo = {w_mulSum[0], r_lo[XLEN-1:1]};
    end
  end

  // Apply sign correction to the final step's values and pick the architectural result.
  always_comb begin
    w_prodRaw = {w_stepHi, w_stepLo};
    w_prodFix = r_negRes ? -w_prodRaw : w_prodRaw;
    w_quoFix  = r_negRes ? -w_stepLo : w_stepLo;
    w_remFix  = r_negRes ? -w_stepHi : w_stepHi;
    w_finalResult = w_remFix;
    unique case (r_op)
      OP_MUL:                       w_finalResult = w_prodFix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_finalResult = w_prodFix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_finalResult = w_quoFix;
      default:                      w_finalResult = w_remFix;
    endcase
  end

  // Sequencer next state; flush overrides every other transition.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_nextState = w_special ? ST_DONE : ST_CALC;
      ST_CALC: if (w_lastStep) w_nextState = ST_DONE;
      ST_DONE: if (out_ready) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
    if (flush) w_nextState = ST_IDLE;
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_nextState;
  end

  // Datapath: capture on acceptance, iterate in CALC, hold the result in DONE, clear it when it leaves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op     <= OP_MUL;
      r_negRes <= 1'b0;
      r_opB    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op     <= w_opIn;
            r_count  <= '0;
            r_hi     <= '0;
            r_negRes <= ((w_opIn == OP_REM) || (w_opIn == OP_REMU)) ? w_signA : (w_signA ^ w_signB);
            if (opIsDiv(w_opIn)) begin
              r_opB <= w_magB;
              r_lo  <= w_magA;
            end else begin
              r_opB <= w_magA;
              r_lo  <= w_magB;
            end
            if (w_special) r_result <= w_specialResult;
          end
        end
        ST_CALC: begin
          r_hi    <= w_stepHi;
          r_lo    <= w_stepLo;
          r_count <= r_count + CNT_W'(1);
          if (w_lastStep) r_result <= w_finalResult;
        end
        ST_DONE: begin
          if (out_ready) r_result <= '0;
        end
        default: r_result <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_muldiv.sv
// Directed self-checking bench for exu_muldiv at XLEN=32.
module tb_exu_muldiv;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int passes = 0;

  exu_muldiv #(.XLEN(32), .OP_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request for one edge, then scramble the inputs so later changes would show up.
  task automatic startOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; op = o; rs1_data = a; rs2_data = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op = o ^ 3'b011; rs1_data = ~a; rs2_data = b + 32'd1;
  endtask

  // Wait (bounded) for out_valid; lat counts edges starting with the acceptance edge.
  task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res);
    startOp(o, a, b);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 0; op = 0; rs1_data = 0; rs2_data = 0; flush = 0; out_ready = 0;
    rst = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (result !== 32'd0) $display("[TB] FAIL reset_result: got %h expected 0", result); else passes++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b1; op = MUL; rs1_data = 32'd3; rs2_data = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL reset_first_accept: busy got %b expected 1", busy); else passes++;
    rst = 1'b0; #1; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int lat; logic [31:0] res;
    runOp(MUL, 32'd7, 32'hFFFFFFFD, lat, res);
    checks++; if (res !== 32'hFFFFFFEB) $display("[TB] FAIL mul_result: got %h expected FFFFFFEB", res); else passes++;
    checks++; if (lat !== 33) $display("[TB] FAIL mul_latency: got %0d expected 33", lat); else passes++;
    consume();
    checks++; if (result !== 32'd0) $display("[TB] FAIL mul_result_cleared: got %h expected 0", result); else passes++;
  endtask

  task automatic test_mulh();
    int lat; logic [31:0] res;
    runOp(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res); consume();
    checks++; if (res !== 32'hFFFFFFFE) $display("[TB] FAIL mulhu_result: got %h expected FFFFFFFE", res); else passes++;
    runOp(MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res); consume();
    checks++; if (res !== 32'h00000000) $display("[TB] FAIL mulh_result: got %h expected 00000000", res); else passes++;
    runOp(MULHSU, 32'hFFFFFFFF, 32'h00000002, lat, res); consume();
    checks++; if (res !== 32'hFFFFFFFF) $display("[TB] FAIL mulhsu_result: got %h expected FFFFFFFF", res); else passes++;
    runOp(MULH, 32'h40000000, 32'hFFFFFFFC, lat, res); consume();
    checks++; if (res !== 32'hFFFFFFFF) $display("[TB] FAIL mulh_neg_result: got %h expected FFFFFFFF", res); else passes++;
  endtask

  task automatic test_div();
    int lat; logic [31:0] res;
    runOp(DIV, 32'hFFFFFFF9, 32'd2, lat, res); consume();
    checks++; if (res !== 32'hFFFFFFFD) $display("[TB] FAIL div_result: got %h expected FFFFFFFD", res); else passes++;
    checks++; if (lat !== 33) $display("[TB] FAIL div_latency: got %0d expected 33", lat); else passes++;
    runOp(REM, 32'hFFFFFFF9, 32'd2, lat, res); consume();
    checks++; if (res !== 32'hFFFFFFFF) $display("[TB] FAIL rem_result: got %h expected FFFFFFFF", res); else passes++;
    runOp(DIV, 32'd7, 32'hFFFFFFFE, lat, res); consume();
    checks++; if (res !== 32'hFFFFFFFD) $display("[TB] FAIL div_negdivisor: got %h expected FFFFFFFD", res); else passes++;
    runOp(REM, 32'd7, 32'hFFFFFFFE, lat, res); consume();
    checks++; if (res !== 32'd1) $display("[TB] FAIL rem_negdivisor: got %h expected 00000001", res); else passes++;
    runOp(DIVU, 32'd100, 32'd7, lat, res); consume();
    checks++; if (res !== 32'd14) $display("[TB] FAIL divu_result: got %h expected 0000000E", res); else passes++;
    runOp(REMU, 32'd100, 32'd7, lat, res); consume();
    checks++; if (res !== 32'd2) $display("[TB] FAIL remu_result: got %h expected 00000002", res); else passes++;
  endtask

  task automatic test_special();
    int lat; logic [31:0] res;
    runOp(DIVU, 32'd5, 32'd0, lat, res); consume();
    checks++; if (res !== 32'hFFFFFFFF) $display("[TB] FAIL divu_zero_result: got %h expected FFFFFFFF", res); else passes++;
    checks++; if (lat !== 1) $display("[TB] FAIL divu_zero_latency: got %0d expected 1", lat); else passes++;
    runOp(REMU, 32'd5, 32'd0, lat, res); consume();
    checks++; if (res !== 32'd5) $display("[TB] FAIL remu_zero_result: got %h expected 00000005", res); else passes++;
    checks++; if (lat !== 1) $display("[TB] FAIL remu_zero_latency: got %0d expected 1", lat); else passes++;
    runOp(DIV, 32'h80000000, 32'hFFFFFFFF, lat, res); consume();
    checks++; if (res !== 32'h80000000) $display("[TB] FAIL div_ovf_result: got %h expected 80000000", res); else passes++;
    checks++; if (lat !== 1) $display("[TB] FAIL div_ovf_latency: got %0d expected 1", lat); else passes++;
    runOp(REM, 32'h80000000, 32'hFFFFFFFF, lat, res); consume();
    checks++; if (res !== 32'd0) $display("[TB] FAIL rem_ovf_result: got %h expected 00000000", res); else passes++;
    runOp(REM, 32'hFFFFFFF9, 32'd0, lat, res); consume();
    checks++; if (res !== 32'hFFFFFFF9) $display("[TB] FAIL rem_zero_result: got %h expected FFFFFFF9", res); else passes++;
  endtask

  task automatic test_flush();
    logic sawValid;
    startOp(MUL, 32'd9, 32'd9);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL flush_in_ready: got %b expected 1", in_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL flush_busy: got %b expected 0", busy); else passes++;
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checks++; if (sawValid !== 1'b0) $display("[TB] FAIL flush_no_result: saw out_valid %b expected 0", sawValid); else passes++;
    in_valid = 1'b1; flush = 1'b1; op = MUL; rs1_data = 32'd2; rs2_data = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL flush_beats_valid: busy got %b expected 0", busy); else passes++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res; logic sawValid;
    startOp(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL rstmid_in_ready: got %b expected 1", in_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); else passes++;
    @(posedge clk); #1;
    rst = 1'b1;
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checks++; if (sawValid !== 1'b0) $display("[TB] FAIL rstmid_no_result: saw out_valid %b expected 0", sawValid); else passes++;
    runOp(MUL, 32'd3, 32'd5, lat, res); consume();
    checks++; if (res !== 32'd15) $display("[TB] FAIL rstmid_recover: got %h expected 0000000F", res); else passes++;
  endtask

  task automatic test_hold();
    int lat; logic [31:0] res; int badCycles;
    runOp(DIV, 32'hFFFFFFF9, 32'd2, lat, res);
    badCycles = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || result !== 32'hFFFFFFFD) badCycles++;
    end
    checks++; if (badCycles !== 0) $display("[TB] FAIL hold_stable: %0d unstable cycles expected 0 (last result %h)", badCycles, result); else passes++;
    consume();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL hold_release: busy %b in_ready %b expected 0/1", busy, in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL hold_out_valid_low: got %b expected 0", out_valid); else passes++;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res;
    runOp(DIVU, 32'd9, 32'd0, lat, res);
    in_valid = 1'b1; op = MUL; rs1_data = 32'd6; rs2_data = 32'd7;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL b2b_ready_in_done: got %b expected 0", in_ready); else passes++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL b2b_no_accept_on_consume: busy got %b expected 0", busy); else passes++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (result !== 32'd42) $display("[TB] FAIL b2b_result: got %h expected 0000002A", result); else passes++;
    consume();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
